// File: rtl/multi_debouncer.sv
// Multi-channel push-button conditioner: synchronise, debounce, and emit
// press / release / long-press pulses per channel. Channels are independent.

module multi_debouncer_ch #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int SYNC_STAGES     = 2,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

  logic                   norm;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic [DW-1:0]          db_cnt;
  logic [HW-1:0]          hold_cnt;

  assign norm     = ACTIVE_LOW ? ~btn : btn;
  assign sync_out = sync[SYNC_STAGES-1];

  // Reset value 0 means "released", so no spurious press after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[SYNC_STAGES-2:0], norm};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt        <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (sync_out == pressed) begin
        db_cnt <= '0;
      end else if (db_cnt == DEB_LAST) begin
        db_cnt        <= '0;
        pressed       <= sync_out;
        press_pulse   <= sync_out;
        release_pulse <= ~sync_out;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  // Saturating hold counter; the pulse fires only on the step into saturation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt         <= '0;
      long_press_pulse <= 1'b0;
    end else begin
      long_press_pulse <= 1'b0;
      if (!pressed) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt         <= hold_cnt + HW'(1);
        long_press_pulse <= (hold_cnt == HOLD_LAST);
      end
    end
  end
endmodule

module multi_debouncer #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int SYNC_STAGES     = 2,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] btn_pressed,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
  output logic [NUM_CH-1:0] long_press_pulse
);
  multi_debouncer_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) u_ch [NUM_CH-1:0] (
    .clk              (clk),
    .reset_n          (reset_n),
    .btn              (btn_in),
    .pressed          (btn_pressed),
    .press_pulse      (press_pulse),
    .release_pulse    (release_pulse),
    .long_press_pulse (long_press_pulse)
  );
endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: directed phase table, exact-latency sequences,
// and random stimulus compared every cycle against a sliding-window model.

module tb_multi_debouncer;
  localparam int NC = 2, DEB = 8, HOLD = 32, SS = 2, HL = SS + DEB;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [NC-1:0] btn_in = '1;
  logic [NC-1:0] btn_pressed, press_pulse, release_pulse, long_press_pulse;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  multi_debouncer #(
    .NUM_CH(NC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .SYNC_STAGES(SS), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_in(btn_in),
    .btn_pressed(btn_pressed), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .long_press_pulse(long_press_pulse)
  );

  // Model: a level is accepted once the synchronised stream has shown the
  // opposite value for a full window of DEB samples; long press is measured
  // as elapsed edges since the accepted press.
  logic [HL-1:0] hist [NC];
  logic [NC-1:0] m_pr = '0, m_pp = '0, m_rp = '0, m_lp = '0;
  int since [NC];
  int edge_n = 0;

  always @(posedge clk or negedge reset_n) begin
    bit all_opp;
    if (!reset_n) begin
      for (int c = 0; c < NC; c++) hist[c] = '0;
      m_pr = '0; m_pp = '0; m_rp = '0; m_lp = '0;
    end else begin
      edge_n++;
      for (int c = 0; c < NC; c++) begin
        hist[c] = {hist[c][HL-2:0], ~btn_in[c]};
        all_opp = 1'b1;
        for (int j = 0; j < DEB; j++)
          if (hist[c][SS+j] == m_pr[c]) all_opp = 1'b0;
        m_lp[c] = m_pr[c] && (edge_n - since[c] == HOLD);
        m_pp[c] = all_opp && !m_pr[c];
        m_rp[c] = all_opp && m_pr[c];
        if (all_opp) begin
          m_pr[c] = ~m_pr[c];
          if (m_pr[c]) since[c] = edge_n;
        end
      end
    end
  end

  int pc [NC], rc [NC], lc [NC];

  task automatic tick();
    @(negedge clk);
    tests++;
    if ({btn_pressed, press_pulse, release_pulse, long_press_pulse} !==
        {m_pr, m_pp, m_rp, m_lp}) begin
      fails++;
      $display("FAIL model_cycle t=%0t: got pr=%b pp=%b rp=%b lp=%b, expected pr=%b pp=%b rp=%b lp=%b",
               $time, btn_pressed, press_pulse, release_pulse, long_press_pulse,
               m_pr, m_pp, m_rp, m_lp);
    end
    for (int c = 0; c < NC; c++) begin
      pc[c] += int'(press_pulse[c]);
      rc[c] += int'(release_pulse[c]);
      lc[c] += int'(long_press_pulse[c]);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic [NC-1:0] btn;
    int            n;
    logic [NC-1:0] epr, epp, erp, elp;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dur [NC];

    // Reset with both buttons held, then release reset.
    btn_in = 2'b00;
    reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", int'({btn_pressed, press_pulse, release_pulse, long_press_pulse}), 0);
    reset_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (press_pulse[0] !== 1'b1 && n < 40);
    chk("first_press_latency", n, 10);
    chk("simultaneous_press", int'(press_pulse), 3);

    tbl[0]  = '{2'b11, 15, 2'b00, 2'b00, 2'b11, 2'b00};
    tbl[1]  = '{2'b10, 20, 2'b01, 2'b01, 2'b00, 2'b00};
    tbl[2]  = '{2'b11, 12, 2'b00, 2'b00, 2'b01, 2'b00};
    tbl[3]  = '{2'b10,  7, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[4]  = '{2'b11,  1, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[5]  = '{2'b10,  7, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[6]  = '{2'b11, 12, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[7]  = '{2'b01, 60, 2'b10, 2'b10, 2'b00, 2'b10};
    tbl[8]  = '{2'b11, 12, 2'b00, 2'b00, 2'b10, 2'b00};
    tbl[9]  = '{2'b01, 30, 2'b10, 2'b10, 2'b00, 2'b00};
    tbl[10] = '{2'b11, 12, 2'b00, 2'b00, 2'b10, 2'b00};

    for (int i = 0; i < 11; i++) begin
      btn_in = tbl[i].btn;
      for (int c = 0; c < NC; c++) begin pc[c] = 0; rc[c] = 0; lc[c] = 0; end
      repeat (tbl[i].n) tick();
      for (int c = 0; c < NC; c++) begin
        chk($sformatf("row%0d_ch%0d_pressed", i, c), int'(btn_pressed[c]), int'(tbl[i].epr[c]));
        chk($sformatf("row%0d_ch%0d_press_cnt", i, c), pc[c], int'(tbl[i].epp[c]));
        chk($sformatf("row%0d_ch%0d_release_cnt", i, c), rc[c], int'(tbl[i].erp[c]));
        chk($sformatf("row%0d_ch%0d_long_cnt", i, c), lc[c], int'(tbl[i].elp[c]));
      end
    end

    // Reset in the middle of a debounce count.
    btn_in = 2'b10;
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    chk("reset_mid_debounce", int'({btn_pressed, press_pulse, release_pulse, long_press_pulse}), 0);
    tick();
    reset_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (press_pulse[0] !== 1'b1 && n < 40);
    chk("press_latency_after_reset", n, 10);

    // Reset at hold count 20; the hold interval must restart from zero.
    repeat (20) tick();
    reset_n = 1'b0;
    tick();
    chk("reset_mid_hold", int'({btn_pressed, press_pulse, release_pulse, long_press_pulse}), 0);
    reset_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (press_pulse[0] !== 1'b1 && n < 40);
    chk("press_latency_after_hold_reset", n, 10);
    n = 0;
    do begin tick(); n++; end while (long_press_pulse[0] !== 1'b1 && n < 60);
    chk("fresh_hold_interval", n, HOLD);
    btn_in = 2'b11;
    repeat (12) tick();

    // Random runs of varying length per channel, with occasional resets.
    for (int c = 0; c < NC; c++) dur[c] = 0;
    for (int r = 0; r < 3000; r++) begin
      reset_n = ($urandom_range(0, 599) != 0);
      for (int c = 0; c < NC; c++) begin
        if (dur[c] == 0) begin
          btn_in[c] = 1'($urandom_range(0, 1));
          dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 60))
                                               : int'($urandom_range(1, 14));
        end
        dur[c]--;
      end
      tick();
    end
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
